// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register IDs and datapath sizes.
package y86_pkg;

    localparam int WIDTH = 64;
    localparam int NREGS = 15;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] R_RSP  = 4'h4;
    localparam logic [3:0] R_NONE = 4'hF;

endpackage

// File: rtl/y86_regfile.sv
// 15 x 64-bit register file: two combinational read ports, two write ports (E, M).
// ID 0xF reads as zero and is never written; port M wins on an address collision.
module y86_regfile
    import y86_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [3:0]                  src_a,
    input  logic [3:0]                  src_b,
    input  logic [3:0]                  dst_e,
    input  logic [3:0]                  dst_m,
    input  logic [WIDTH-1:0]            wr_e,
    input  logic [WIDTH-1:0]            wr_m,
    output logic [WIDTH-1:0]            rd_a,
    output logic [WIDTH-1:0]            rd_b,
    output logic [NREGS-1:0][WIDTH-1:0] regs
);

    logic [NREGS-1:0][WIDTH-1:0] regs_q;
    logic [NREGS-1:0][WIDTH-1:0] regs_d;

    // M is applied after E so that popq %rsp keeps the loaded value.
    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NREGS; i++) begin
            if (dst_e == 4'(i)) begin
                regs_d[i] = wr_e;
            end
            if (dst_m == 4'(i)) begin
                regs_d[i] = wr_m;
            end
        end
    end

    always_comb begin
        rd_a = '0;
        rd_b = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (src_a == 4'(i)) begin
                rd_a = regs_q[i];
            end
            if (src_b == 4'(i)) begin
                rd_b = regs_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    assign regs = regs_q;

endmodule

// File: rtl/y86_decode_regfile.sv
// SEQ Y86-64 decode/write-back stage: picks source/destination register IDs from
// icode/rA/rB and drives the register file, exporting every register for debug.
module y86_decode_regfile
    import y86_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       icode,
    input  logic [3:0]       rA,
    input  logic [3:0]       rB,
    input  logic [WIDTH-1:0] valE,
    input  logic [WIDTH-1:0] valF,
    output logic [WIDTH-1:0] valA,
    output logic [WIDTH-1:0] valB,
    output logic [WIDTH-1:0] rm0,
    output logic [WIDTH-1:0] rm1,
    output logic [WIDTH-1:0] rm2,
    output logic [WIDTH-1:0] rm3,
    output logic [WIDTH-1:0] rm4,
    output logic [WIDTH-1:0] rm5,
    output logic [WIDTH-1:0] rm6,
    output logic [WIDTH-1:0] rm7,
    output logic [WIDTH-1:0] rm8,
    output logic [WIDTH-1:0] rm9,
    output logic [WIDTH-1:0] rm10,
    output logic [WIDTH-1:0] rm11,
    output logic [WIDTH-1:0] rm12,
    output logic [WIDTH-1:0] rm13,
    output logic [WIDTH-1:0] rm14
);

    logic [3:0]                  src_a;
    logic [3:0]                  src_b;
    logic [3:0]                  dst_e;
    logic [3:0]                  dst_m;
    logic [NREGS-1:0][WIDTH-1:0] regs;

    // cmovXX writes unconditionally here; condition gating is resolved in execute.
    always_comb begin
        src_a = R_NONE;
        src_b = R_NONE;
        dst_e = R_NONE;
        dst_m = R_NONE;
        case (icode)
            I_HALT, I_NOP, I_JXX: ;
            I_RRMOVQ: begin
                src_a = rA;
                dst_e = rB;
            end
            I_IRMOVQ: dst_e = rB;
            I_RMMOVQ: begin
                src_a = rA;
                src_b = rB;
            end
            I_MRMOVQ: begin
                src_b = rB;
                dst_m = rA;
            end
            I_OPQ: begin
                src_a = rA;
                src_b = rB;
                dst_e = rB;
            end
            I_CALL: begin
                src_b = R_RSP;
                dst_e = R_RSP;
            end
            I_RET: begin
                src_a = R_RSP;
                src_b = R_RSP;
                dst_e = R_RSP;
            end
            I_PUSHQ: begin
                src_a = rA;
                src_b = R_RSP;
                dst_e = R_RSP;
            end
            I_POPQ: begin
                src_a = R_RSP;
                src_b = R_RSP;
                dst_e = R_RSP;
                dst_m = rA;
            end
            default: ;
        endcase
    end

    y86_regfile u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .src_a (src_a),
        .src_b (src_b),
        .dst_e (dst_e),
        .dst_m (dst_m),
        .wr_e  (valE),
        .wr_m  (valF),
        .rd_a  (valA),
        .rd_b  (valB),
        .regs  (regs)
    );

    assign rm0  = regs[0];
    assign rm1  = regs[1];
    assign rm2  = regs[2];
    assign rm3  = regs[3];
    assign rm4  = regs[4];
    assign rm5  = regs[5];
    assign rm6  = regs[6];
    assign rm7  = regs[7];
    assign rm8  = regs[8];
    assign rm9  = regs[9];
    assign rm10 = regs[10];
    assign rm11 = regs[11];
    assign rm12 = regs[12];
    assign rm13 = regs[13];
    assign rm14 = regs[14];

endmodule

// File: tb/tb_y86_decode_regfile.sv
// Randomized bench for y86_decode_regfile, checked against an array-based model
// of the Y86-64 decode/write-back rules plus directed scenarios with fixed values.
module tb_y86_decode_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  icode, rA, rB;
    logic [63:0] valE, valF, valA, valB;
    logic [63:0] rm [15];

    logic [63:0] model [15];
    logic [63:0] lastValA, lastValB;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    y86_decode_regfile dut (
        .clk(clk), .rst_n(rst_n), .icode(icode), .rA(rA), .rB(rB),
        .valE(valE), .valF(valF), .valA(valA), .valB(valB),
        .rm0(rm[0]), .rm1(rm[1]), .rm2(rm[2]), .rm3(rm[3]), .rm4(rm[4]),
        .rm5(rm[5]), .rm6(rm[6]), .rm7(rm[7]), .rm8(rm[8]), .rm9(rm[9]),
        .rm10(rm[10]), .rm11(rm[11]), .rm12(rm[12]), .rm13(rm[13]), .rm14(rm[14])
    );

    // Register-selection rules written as instruction-class membership tests.
    function automatic logic [3:0] refSrcA(input logic [3:0] ic, input logic [3:0] a);
        if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return a;
        if (ic inside {4'h9, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] refSrcB(input logic [3:0] ic, input logic [3:0] b);
        if (ic inside {4'h4, 4'h5, 4'h6}) return b;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] refDstE(input logic [3:0] ic, input logic [3:0] b);
        if (ic inside {4'h2, 4'h3, 4'h6}) return b;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] refDstM(input logic [3:0] ic, input logic [3:0] a);
        if (ic inside {4'h5, 4'hB}) return a;
        return 4'hF;
    endfunction

    function automatic logic [63:0] modelRead(input logic [3:0] id);
        if (id == 4'hF) return 64'd0;
        return model[id];
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic checkAllRegs(input string tag);
        for (int i = 0; i < 15; i++) begin
            checkOutput($sformatf("%s_rm%0d", tag, i), rm[i], model[i]);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < 15; i++) model[i] = 64'd0;
    endtask

    // Called shortly after a rising edge: drive, check reads, clock, check write-back.
    task automatic applyStimulus(input logic [3:0] ic, input logic [3:0] a,
                                 input logic [3:0] b, input logic [63:0] e,
                                 input logic [63:0] f);
        logic [3:0] de, dm;
        icode = ic; rA = a; rB = b; valE = e; valF = f;
        #2;
        lastValA = valA;
        lastValB = valB;
        checkOutput("valA", valA, modelRead(refSrcA(ic, a)));
        checkOutput("valB", valB, modelRead(refSrcB(ic, b)));
        @(posedge clk);
        de = refDstE(ic, b);
        dm = refDstM(ic, a);
        if (de != 4'hF) model[de] = e;
        if (dm != 4'hF) model[dm] = f;
        #1;
        checkAllRegs("wb");
    endtask

    // Asserts reset mid-cycle with a write pending, then holds it across an edge.
    task automatic midCycleReset();
        icode = 4'h3; rA = 4'hF; rB = 4'h1; valE = 64'd5; valF = 64'd5;
        #1;
        rst_n = 1'b0;
        clearModel();
        #1;
        checkAllRegs("rst_now");
        checkOutput("rst_valA", valA, 64'd0);
        @(posedge clk);
        #1;
        checkAllRegs("rst_held");
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] noWriteCodes [4];
        rst_n = 1'b0;
        icode = 4'h0; rA = 4'hF; rB = 4'hF; valE = '0; valF = '0;
        clearModel();
        @(posedge clk);
        #1;
        checkAllRegs("reset");
        rst_n = 1'b1;

        applyStimulus(4'h3, 4'hF, 4'h3, 64'd100, 64'd0);
        checkOutput("irmovq_rm3", rm[3], 64'd100);
        checkOutput("irmovq_valA", lastValA, 64'd0);
        checkOutput("irmovq_valB", lastValB, 64'd0);

        applyStimulus(4'h3, 4'hF, 4'h2, 64'd7, 64'd0);
        applyStimulus(4'h6, 4'h2, 4'h3, 64'd107, 64'd0);
        checkOutput("opq_valA", lastValA, 64'd7);
        checkOutput("opq_valB", lastValB, 64'd100);
        checkOutput("opq_rm3", rm[3], 64'd107);

        applyStimulus(4'h3, 4'hF, 4'h4, 64'd64, 64'd0);
        applyStimulus(4'h3, 4'hF, 4'h1, 64'd9, 64'd0);
        applyStimulus(4'hA, 4'h1, 4'hF, 64'd56, 64'd0);
        checkOutput("pushq_valA", lastValA, 64'd9);
        checkOutput("pushq_valB", lastValB, 64'd64);
        checkOutput("pushq_rsp", rm[4], 64'd56);
        applyStimulus(4'h3, 4'hF, 4'h1, 64'd0, 64'd0);
        applyStimulus(4'hB, 4'h1, 4'hF, 64'd64, 64'd9);
        checkOutput("popq_rsp", rm[4], 64'd64);
        checkOutput("popq_r1", rm[1], 64'd9);

        applyStimulus(4'hB, 4'h4, 4'hF, 64'd200, 64'd300);
        checkOutput("popq_rsp_collide", rm[4], 64'd300);

        noWriteCodes = '{4'h0, 4'h1, 4'h7, 4'hD};
        foreach (noWriteCodes[k]) begin
            applyStimulus(noWriteCodes[k], 4'h2, 4'h3, 64'd55, 64'd55);
            checkOutput("nowrite_valA", lastValA, 64'd0);
            checkOutput("nowrite_valB", lastValB, 64'd0);
        end
        checkOutput("nowrite_rm3", rm[3], 64'd107);

        applyStimulus(4'h5, 4'h6, 4'h2, 64'd11, 64'd77);
        checkOutput("mrmovq_r6", rm[6], 64'd77);
        checkOutput("mrmovq_valB", lastValB, 64'd7);

        midCycleReset();
        applyStimulus(4'h3, 4'hF, 4'h1, 64'd42, 64'd0);
        checkOutput("post_reset_r1", rm[1], 64'd42);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                midCycleReset();
            end else begin
                applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                              4'($urandom_range(0, 15)), {$urandom, $urandom},
                              {$urandom, $urandom});
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no completion, expected $finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
